seq_accumulator: RTL

- Parametrised sequential accumulator, successor to the fixed 16-bit go_l/inA summing datapath.
- Starts on active-low go_l and sums a stream of unsigned inA words, one per clock, until a zero terminator word.
- Publishes the result and word count with a held done flag.
- Adds configurable widths, optional saturation, a maximum sequence length with error flag, and restart-on-go.

---
 rtl/seq_accumulator.sv | 128 ++++++++++++
 1 files changed

// File: rtl/seq_accumulator.sv
// Sequential accumulator: sums a stream of unsigned words started by go_l until a
// zero terminator word or MAX_LEN non-zero words, then holds the result with done.
module seq_accumulator #(
  parameter int WIDTH     = 16,
  parameter int SUM_WIDTH = 16,
  parameter int MAX_LEN   = 255,
  parameter int SATURATE  = 0,
  localparam int CNT_W    = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     inA,
  input  logic                 go_l,
  output logic [SUM_WIDTH-1:0] sum,
  output logic [SUM_WIDTH-1:0] outResult,
  output logic [CNT_W-1:0]     count,
  output logic                 done,
  output logic                 busy,
  output logic                 overflow,
  output logic                 lenErr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SUM_WIDTH-1:0] sum_q, sum_d;
  logic [SUM_WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 len_err_q, len_err_d;

  logic [SUM_WIDTH-1:0] in_ext;
  logic [SUM_WIDTH:0]   add_full;
  logic                 add_carry;
  logic [SUM_WIDTH-1:0] add_sum;
  logic [CNT_W-1:0]     count_inc;

  // The add is one bit wider than the accumulator so the carry-out flags overflow.
  always_comb begin
    in_ext             = '0;
    in_ext[WIDTH-1:0]  = inA;
    add_full           = {1'b0, sum_q} + {1'b0, in_ext};
    add_carry          = add_full[SUM_WIDTH];
    add_sum            = add_full[SUM_WIDTH-1:0];
    if (add_carry && (SATURATE != 0)) begin
      add_sum = '1;
    end
    count_inc = count_q + CNT_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    result_d   = result_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    len_err_d  = len_err_q;

    // go_l low starts a new sequence from any state, discarding work in progress.
    if (!go_l) begin
      overflow_d = 1'b0;
      len_err_d  = 1'b0;
      if (inA != '0) begin
        sum_d   = in_ext;
        count_d = CNT_W'(1);
        if (MAX_LEN == 1) begin
          state_d   = DONE;
          len_err_d = 1'b1;
          result_d  = in_ext;
        end else begin
          state_d = ACCUM;
        end
      end else begin
        sum_d    = '0;
        count_d  = '0;
        result_d = '0;
        state_d  = DONE;
      end
    end else if (state_q == ACCUM) begin
      if (inA == '0) begin
        result_d = sum_q;
        state_d  = DONE;
      end else begin
        sum_d   = add_sum;
        count_d = count_inc;
        if (add_carry) begin
          overflow_d = 1'b1;
        end
        if (count_inc == CNT_W'(MAX_LEN)) begin
          result_d  = add_sum;
          len_err_d = 1'b1;
          state_d   = DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sum_q      <= '0;
      result_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      result_q   <= result_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      len_err_q  <= len_err_d;
    end
  end

  assign sum       = sum_q;
  assign outResult = result_q;
  assign count     = count_q;
  assign done      = (state_q == DONE);
  assign busy      = (state_q == ACCUM);
  assign overflow  = overflow_q;
  assign lenErr    = len_err_q;

endmodule
